// File: rtl/load_store_unit_if.sv
// Word-wide ack-handshake data bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_strobe,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_strobe,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load/store per request on an ack-handshake bus,
// with byte strobes, lane-replicated store data, load extension, and misalign/timeout traps.
module load_store_unit #(
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        cuOP,
  input  logic [31:0]       addr,
  input  logic [31:0]       storeData,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [31:0]       loadData,
  load_store_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [1:0]       r_off;
  logic             r_is_store;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_strobe;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_load_data;

  logic             w_is_mem;
  logic             w_is_store;
  logic             w_misaligned;
  logic             w_accept;
  logic [3:0]       w_strobe;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_ext;

  assign w_is_mem   = (cuOP >= OP_LB) && (cuOP <= OP_SW);
  assign w_is_store = (cuOP >= OP_SB) && (cuOP <= OP_SW);
  assign w_accept   = (r_state == S_IDLE) && start && w_is_mem;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_misaligned = 1'b0;
    w_strobe     = 4'b0000;
    w_wdata      = 32'h0;
    case (cuOP)
      OP_LH, OP_LHU: w_misaligned = addr[0];
      OP_LW:         w_misaligned = (addr[1:0] != 2'b00);
      OP_SB: begin
        w_strobe = 4'b0001 << addr[1:0];
        w_wdata  = {4{storeData[7:0]}};
      end
      OP_SH: begin
        w_misaligned = addr[0];
        w_strobe     = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{storeData[15:0]}};
      end
      OP_SW: begin
        w_misaligned = (addr[1:0] != 2'b00);
        w_strobe     = 4'b1111;
        w_wdata      = storeData;
      end
      default: ;
    endcase
  end

  // Lane selection uses the latched offset, since addr may change while the bus is busy.
  always_comb begin
    w_byte     = bus.mem_rdata[{r_off, 3'b000} +: 8];
    w_half     = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    w_load_ext = bus.mem_rdata;
    case (r_op)
      OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_ext = {24'h0, w_byte};
      OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misaligned ? S_ERR : S_REQ;
      S_REQ: begin
        if (bus.mem_ack)            w_next = S_RESP;
        else if (r_cnt == CNT_LAST) w_next = S_ERR;
      end
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= 6'h0;
      r_off       <= 2'b00;
      r_is_store  <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_wdata     <= 32'h0;
      r_strobe    <= 4'b0000;
      r_cnt       <= '0;
      r_load_data <= 32'h0;
    end else begin
      if (w_accept) begin
        r_op       <= cuOP;
        r_off      <= addr[1:0];
        r_is_store <= w_is_store;
        r_mem_addr <= {addr[31:2], 2'b00};
        r_wdata    <= w_wdata;
        r_strobe   <= w_strobe;
        r_cnt      <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == S_REQ) && bus.mem_ack && !r_is_store)
        r_load_data <= w_load_ext;
    end
  end

  assign ready          = (r_state == S_IDLE);
  assign done           = (r_state == S_RESP) || (r_state == S_ERR);
  assign error          = (r_state == S_ERR);
  assign loadData       = r_load_data;
  assign bus.mem_ren    = (r_state == S_REQ) && !r_is_store;
  assign bus.mem_wen    = (r_state == S_REQ) && r_is_store;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_strobe = r_strobe;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts the per-cycle
// timeline (bus signals, done/error, latency, held load data) and one negedge process compares it.
module tb_load_store_unit;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rdata;
    int          waits;
    logic        store;
    logic        misal;
    logic        err;
    int          lat;
    logic [31:0] waddr;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic [31:0] ld;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  cuOP;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        ready;
  logic        done;
  logic        error;
  logic [31:0] loadData;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cuOP      (cuOP),
    .addr      (addr),
    .storeData (storeData),
    .ready     (ready),
    .done      (done),
    .error     (error),
    .loadData  (loadData),
    .bus       (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  txn_t        cur;
  bit          in_txn   = 0;
  bit          chk_en   = 0;
  int          k        = 0;
  logic [31:0] model_load = 32'h0;
  int          req_n    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: what one request must produce, from the ISA-level rules.
  function automatic txn_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int waits);
    txn_t        t;
    int          size;
    int          off;
    logic [31:0] b;
    logic [31:0] h;
    t.op    = op;
    t.rdata = rd;
    t.waits = waits;
    size    = (op == 10 || op == 13 || op == 15) ? 1 : (op == 11 || op == 14 || op == 16) ? 2 : 4;
    off     = int'(a[1:0]);
    t.store = (op >= 15);
    t.misal = (off % size) != 0;
    t.err   = t.misal || (waits >= TIMEOUT);
    t.lat   = t.misal ? 1 : (waits >= TIMEOUT) ? TIMEOUT + 1 : 2 + waits;
    t.waddr = a - 32'(off);
    t.strobe = t.store ? 4'(((1 << size) - 1) << off) : 4'h0;
    t.wdata  = (size == 1) ? sd[7:0] * 32'h01010101 : (size == 2) ? sd[15:0] * 32'h00010001 : sd;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      6'd10:   t.ld = (b >= 128) ? b - 32'd256 : b;
      6'd11:   t.ld = (h >= 32768) ? h - 32'd65536 : h;
      6'd12:   t.ld = rd;
      6'd13:   t.ld = b;
      6'd14:   t.ld = h;
      default: t.ld = 32'h0;
    endcase
    return t;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after cur.waits request cycles; drives noise acks when no request is open.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_ren || bus.mem_wen) begin
        if (req_n == cur.waits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = cur.rdata;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
        end
        req_n++;
      end else begin
        req_n         = 0;
        bus.mem_ack   = 1'($urandom % 2);
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Per-cycle compare against the model timeline; k counts cycles since the accepting edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (in_txn) begin
          k++;
          if (k < cur.lat) begin
            check("busy_ready", 32'(ready), 32'h0);
            check("busy_done", 32'(done), 32'h0);
            check("req_ren", 32'(bus.mem_ren), 32'(!cur.store));
            check("req_wen", 32'(bus.mem_wen), 32'(cur.store));
            check("req_addr", bus.mem_addr, cur.waddr);
            check("req_strobe", 32'(bus.mem_strobe), 32'(cur.strobe));
            if (cur.store) check("req_wdata", bus.mem_wdata, cur.wdata);
            check("busy_load", loadData, model_load);
          end else begin
            if (!cur.err && !cur.store) model_load = cur.ld;
            check("done", 32'(done), 32'h1);
            check("done_error", 32'(error), 32'(cur.err));
            check("done_ready", 32'(ready), 32'h0);
            check("done_ren", 32'(bus.mem_ren), 32'h0);
            check("done_wen", 32'(bus.mem_wen), 32'h0);
            check("done_load", loadData, model_load);
            in_txn = 0;
          end
        end else begin
          check("idle_ready", 32'(ready), 32'h1);
          check("idle_done", 32'(done), 32'h0);
          check("idle_ren", 32'(bus.mem_ren), 32'h0);
          check("idle_wen", 32'(bus.mem_wen), 32'h0);
          check("idle_load", loadData, model_load);
        end
      end
    end
  end

  task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int waits, input bit noise, input int rst_at);
    bit in_rst = 0;
    cur = model(op, a, sd, rd, waits);
    @(posedge clk); #1;
    start = 1'b1; cuOP = op; addr = a; storeData = sd;
    @(posedge clk); #1;
    start = 1'b0; cuOP = 6'($urandom); addr = $urandom; storeData = $urandom;
    k = 0;
    in_txn = 1;
    for (int c = 0; c < 2 * TIMEOUT + 20 && in_txn; c++) begin
      @(posedge clk); #1;
      if (in_rst) begin
        rst = 1'b0;
        in_rst = 0;
        in_txn = 0;
        model_load = 32'h0;
      end else if (c == rst_at) begin
        rst = 1'b1;
        in_rst = 1;
      end
      if (in_txn && noise && ($urandom % 2 == 1)) begin
        start = 1'b1; cuOP = 6'($urandom); addr = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (in_txn) begin
      check("txn_budget", 32'h0, 32'h1);
      in_txn = 0;
    end
  endtask

  task automatic idle_noise();
    logic [5:0] v;
    v = 6'($urandom % 64);
    if (v >= 10 && v <= 17) v = v + 6'd8;
    @(posedge clk); #1;
    start = 1'b1; cuOP = v; addr = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    txn_t t;
    rst = 1'b1; start = 1'b0; cuOP = 6'h0; addr = 32'h0; storeData = 32'h0;
    cur = model(6'd12, 32'h0, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_load", loadData, 32'h0);
    check("rst_ren", 32'(bus.mem_ren), 32'h0);
    check("rst_wen", 32'(bus.mem_wen), 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_strobe", 32'(bus.mem_strobe), 32'h0);
    rst = 1'b0;
    chk_en = 1;

    // Hand-computed pins on the model itself.
    t = model(6'd12, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("pin_lw_lat", 32'(t.lat), 32'd2);
    check("pin_lw_addr", t.waddr, 32'h100);
    t = model(6'd10, 32'h203, 32'h0, 32'h80112233, 0);
    check("pin_lb_ld", t.ld, 32'hFFFFFF80);
    t = model(6'd13, 32'h203, 32'h0, 32'h80112233, 0);
    check("pin_lbu_ld", t.ld, 32'h00000080);
    t = model(6'd16, 32'h12, 32'h0000ABCD, 32'h0, 0);
    check("pin_sh_strobe", 32'(t.strobe), 32'hC);
    check("pin_sh_wdata", t.wdata, 32'hABCDABCD);
    check("pin_sh_addr", t.waddr, 32'h10);
    t = model(6'd12, 32'h102, 32'h0, 32'h0, 0);
    check("pin_mis_lat", 32'(t.lat), 32'd1);
    t = model(6'd17, 32'h40, 32'h0, 32'h0, 100);
    check("pin_to_lat", 32'(t.lat), 32'd5);

    // Directed scenarios, each also checked cycle-by-cycle by the compare process.
    run_txn(6'd12, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, -1);
    check("lw_load", loadData, 32'hDEADBEEF);
    run_txn(6'd10, 32'h203, 32'h0, 32'h80112233, 1, 0, -1);
    check("lb_load", loadData, 32'hFFFFFF80);
    run_txn(6'd13, 32'h203, 32'h0, 32'h80112233, 0, 0, -1);
    check("lbu_load", loadData, 32'h00000080);
    run_txn(6'd16, 32'h12, 32'h0000ABCD, 32'h0, 2, 0, -1);
    run_txn(6'd12, 32'h102, 32'h0, 32'h12345678, 0, 0, -1);
    check("mis_load_held", loadData, 32'h00000080);
    run_txn(6'd17, 32'h40, 32'h55AA55AA, 32'h0, 100, 0, -1);
    check("to_ready", 32'(ready), 32'h1);
    run_txn(6'd11, 32'h22, 32'h0, 32'h9000ABCD, 3, 0, 0);
    repeat (3) idle_noise();

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int r;
      int w;
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'b00;
      r = int'($urandom % 10);
      w = (r < 6) ? r % 3 : (r < 8) ? 3 : 4 + int'($urandom % 3);
      run_txn(6'(10 + $urandom % 8), a, $urandom, $urandom, w, 1, -1);
      if ($urandom % 4 == 0) idle_noise();
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
